// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB types and constants for the AHB-to-APB bridge.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    BR_IDLE   = 3'd0,
    BR_WDATA  = 3'd1,
    BR_SETUP  = 3'd2,
    BR_ACCESS = 3'd3,
    BR_ERR1   = 3'd4,
    BR_ERR2   = 3'd5
  } br_state_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB address decoder over a power-of-two window map.
module apb_addr_decoder #(
  parameter int                NSLV     = 4,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] BASE     = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLV_SIZE = 32'h0400_0000
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [NSLV-1:0]   sel
);

  localparam int SHIFT = $clog2(SLV_SIZE);
  // One bit wider so the end of the map cannot wrap at the top of the address space.
  localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE} + ((ADDR_W+1)'(NSLV) * {1'b0, SLV_SIZE});

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] index;

  // Range check and one-hot select from the window index.
  always_comb begin
    hit    = ({1'b0, addr} >= {1'b0, BASE}) && ({1'b0, addr} < LIMIT);
    offset = addr - BASE;
    index  = offset >> SHIFT;
    for (int i = 0; i < NSLV; i++) begin
      sel[i] = hit && (index == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_nslv.sv
// AHB slave to APB master bridge with NSLV one-hot selects, wait states,
// slave/decode error reporting and an ACCESS wait-state timeout.
//
// state   | meaning
// IDLE    | no transfer, ready to sample the AHB address phase
// WDATA   | capture AHB write data into Pwdata
// SETUP   | APB setup phase (Pselx set, Penable low)
// ACCESS  | APB access phase, waiting on Pready
// ERR1    | first ERROR response cycle (Hreadyout low)
// ERR2    | second ERROR response cycle (Hreadyout high, samples next)
module ahb_apb_bridge_nslv
  import ahb_apb_pkg::*;
#(
  parameter int                NSLV     = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] BASE     = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLV_SIZE = 32'h0400_0000,
  parameter int                TIMEOUT  = 16
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  output logic              Hreadyout,
  output logic [1:0]        Hresp,
  output logic [DATA_W-1:0] Hrdata,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Pwrite,
  output logic              Penable,
  output logic [NSLV-1:0]   Pselx,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  input  logic              Pslverr
);

  br_state_t       state;
  logic [15:0]     wait_cnt;
  logic [NSLV-1:0] sel_q;
  logic [NSLV-1:0] dec_sel;
  logic            dec_hit;
  logic            sampling;
  logic            accept;
  logic            timeout_hit;

  apb_addr_decoder #(
    .NSLV     (NSLV),
    .ADDR_W   (ADDR_W),
    .BASE     (BASE),
    .SLV_SIZE (SLV_SIZE)
  ) u_dec (
    .addr (Haddr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  // The bridge looks at a new address phase when idle, in the second error
  // cycle, or in the cycle an APB access completes cleanly (pipelining).
  assign sampling    = (state == BR_IDLE) || (state == BR_ERR2) ||
                       ((state == BR_ACCESS) && Pready && !Pslverr);
  assign accept      = sampling && Hreadyin &&
                       ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == 16'(TIMEOUT - 1));

  // AHB response outputs decoded from the current state and APB handshake.
  always_comb begin
    Hreadyout = 1'b0;
    Hresp     = HRESP_OKAY;
    Hrdata    = '0;
    case (state)
      BR_IDLE: Hreadyout = 1'b1;
      BR_ACCESS: begin
        Hreadyout = Pready && !Pslverr;
        if (Pready && !Pwrite) Hrdata = Prdata;
      end
      BR_ERR1: Hresp = HRESP_ERROR;
      BR_ERR2: begin
        Hresp     = HRESP_ERROR;
        Hreadyout = 1'b1;
      end
      default: ;
    endcase
  end

  // Bridge FSM with registered APB outputs.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state    <= BR_IDLE;
      wait_cnt <= '0;
      sel_q    <= '0;
      Paddr    <= '0;
      Pwdata   <= '0;
      Pwrite   <= 1'b0;
      Penable  <= 1'b0;
      Pselx    <= '0;
    end else begin
      Penable <= 1'b0;
      Pselx   <= '0;
      case (state)
        BR_WDATA: begin
          Pwdata <= Hwdata;
          Pselx  <= sel_q;
          state  <= BR_SETUP;
        end
        BR_SETUP: begin
          Pselx    <= sel_q;
          Penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= BR_ACCESS;
        end
        BR_ACCESS: begin
          if (!Pready) begin
            wait_cnt <= wait_cnt + 16'd1;
            if (timeout_hit) begin
              state <= BR_ERR1;
            end else begin
              Pselx   <= sel_q;
              Penable <= 1'b1;
            end
          end else if (Pslverr) begin
            state <= BR_ERR1;
          end
        end
        BR_ERR1: state <= BR_ERR2;
        default: ;
      endcase
      // Shared sampling path for IDLE, ERR2 and a clean ACCESS completion.
      if (sampling) begin
        state <= BR_IDLE;
        if (accept) begin
          if (dec_hit) begin
            Paddr  <= Haddr;
            Pwrite <= Hwrite;
            sel_q  <= dec_sel;
            if (Hwrite) begin
              state <= BR_WDATA;
            end else begin
              Pselx <= dec_sel;
              state <= BR_SETUP;
            end
          end else begin
            state <= BR_ERR1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_nslv.sv
// Scoreboard bench for ahb_apb_bridge_nslv with directed AHB transfers.
module tb_ahb_apb_bridge_nslv;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Pwrite;
  logic        Penable;
  logic [3:0]  Pselx;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  ahb_apb_bridge_nslv #(
    .NSLV(4), .ADDR_W(32), .DATA_W(32),
    .BASE(32'h8000_0000), .SLV_SIZE(32'h0400_0000), .TIMEOUT(4)
  ) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Hreadyout(Hreadyout),
    .Hresp(Hresp), .Hrdata(Hrdata), .Paddr(Paddr), .Pwdata(Pwdata),
    .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx), .Prdata(Prdata),
    .Pready(Pready), .Pslverr(Pslverr)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    bit          err;
    logic [31:0] paddr;
    logic [3:0]  sel;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // APB slave model configuration
  int          cfg_wait  = 0;
  bit          cfg_hang  = 0;
  bit          cfg_err   = 0;
  logic [31:0] cfg_rdata = 32'h0;
  int          wcnt      = 0;
  logic        rdy_s     = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // APB slave: Pready low for cfg_wait ACCESS cycles, then high.
  always @(posedge Hclk) begin
    #1;
    if (Pselx != 4'b0 && !Penable) wcnt = cfg_wait + 1;
    else if (Penable && wcnt > 0) wcnt = wcnt - 1;
    Pready  = (wcnt == 0) && !cfg_hang;
    Pslverr = cfg_err && Pready;
    Prdata  = cfg_rdata;
  end

  // Hreadyout as seen just before the next rising edge.
  always @(negedge Hclk) rdy_s = Hreadyout;

  // Monitor: pops an expectation whenever the bridge completes or errors.
  always @(negedge Hclk) begin
    exp_t e;
    bit ok_ev, err_ev;
    if (Hresetn) begin
      ok_ev  = Hreadyout && Penable;
      err_ev = (Hresp == 2'b01) && !Hreadyout;
      if (ok_ev || err_ev) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_response: got err=%0d ok=%0d with nothing expected", err_ev, ok_ev);
        end else begin
          e = exp_q.pop_front();
          chk("resp_kind", 64'(err_ev), 64'(e.err));
          if (!e.err && ok_ev) begin
            chk("paddr", 64'(Paddr), 64'(e.paddr));
            chk("pselx", 64'(Pselx), 64'(e.sel));
            chk("pwrite", 64'(Pwrite), 64'(e.wr));
            if (e.wr) chk("pwdata", 64'(Pwdata), 64'(e.wdata));
            else      chk("hrdata", 64'(Hrdata), 64'(e.rdata));
          end
        end
      end
    end
  end

  function automatic exp_t mk(input bit err, input logic [31:0] a, input logic [3:0] s,
                              input bit wr, input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.err = err; e.paddr = a; e.sel = s; e.wr = wr; e.wdata = wd; e.rdata = rd;
    return e;
  endfunction

  // Issue one AHB transfer; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                       input bit push, input exp_t e);
    int n = 0;
    if (push) exp_q.push_back(e);
    Htrans = 2'b10;
    Haddr  = a;
    Hwrite = wr;
    forever begin
      @(posedge Hclk);
      if (rdy_s) break;
      n++;
      if (n > 50) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: addr %h not accepted in 50 cycles", a);
        break;
      end
    end
    #1;
    Htrans = 2'b00;
    Hwdata = wd;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge Hclk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Hresetn = 1'b0; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00;
    Haddr = 32'h0; Hwdata = 32'h0; Prdata = 32'h0; Pready = 1'b1; Pslverr = 1'b0;

    // Reset and idle
    repeat (3) @(posedge Hclk);
    @(negedge Hclk);
    chk("rst_paddr",  64'(Paddr), 64'h0);
    chk("rst_pwdata", 64'(Pwdata), 64'h0);
    chk("rst_apb",    64'({Pwrite, Penable, Pselx}), 64'h0);
    chk("rst_ahb",    64'({Hreadyout, Hresp}), 64'b100);
    chk("rst_hrdata", 64'(Hrdata), 64'h0);
    Hresetn = 1'b1;
    idle_cycles(2);

    // Single zero-wait write
    issue(32'h8400_0010, 1, 32'hA5A5_0001, 1, mk(0, 32'h8400_0010, 4'b0010, 1, 32'hA5A5_0001, 0));
    @(negedge Hclk);
    chk("wr_t1", 64'({Pselx, Penable, Hreadyout}), 64'({4'b0000, 1'b0, 1'b0}));
    @(negedge Hclk);
    chk("wr_t2", 64'({Pselx, Penable, Hreadyout}), 64'({4'b0010, 1'b0, 1'b0}));
    @(negedge Hclk);
    chk("wr_t3", 64'({Pselx, Penable, Hreadyout}), 64'({4'b0010, 1'b1, 1'b1}));
    idle_cycles(2);

    // Read with two wait states
    cfg_wait = 2; cfg_rdata = 32'h1234_5678;
    issue(32'h8800_0004, 0, 32'h0, 1, mk(0, 32'h8800_0004, 4'b0100, 0, 0, 32'h1234_5678));
    @(negedge Hclk);
    @(negedge Hclk);
    chk("rdw_t2_rdy", 64'(Hreadyout), 64'h0);
    @(negedge Hclk);
    chk("rdw_t3_rdy", 64'(Hreadyout), 64'h0);
    @(negedge Hclk);
    chk("rdw_t4", 64'({Hreadyout, Hrdata}), {31'h0, 1'b1, 32'h1234_5678});
    idle_cycles(2);

    // Back-to-back read then write
    cfg_wait = 0; cfg_rdata = 32'hCAFE_0000;
    issue(32'h8000_0000, 0, 32'h0, 1, mk(0, 32'h8000_0000, 4'b0001, 0, 0, 32'hCAFE_0000));
    issue(32'h8C00_0000, 1, 32'h0000_BEEF, 1, mk(0, 32'h8C00_0000, 4'b1000, 1, 32'h0000_BEEF, 0));
    @(negedge Hclk);
    chk("b2b_wdata", 64'({Pselx, Penable, Hreadyout}), 64'({4'b0000, 1'b0, 1'b0}));
    @(negedge Hclk);
    chk("b2b_setup", 64'({Pselx, Penable}), 64'({4'b1000, 1'b0}));
    idle_cycles(3);

    // Decode miss above the map
    issue(32'h9000_0000, 0, 32'h0, 1, mk(1, 0, 0, 0, 0, 0));
    @(negedge Hclk);
    chk("miss_t1", 64'({Hresp, Hreadyout, Pselx}), 64'({2'b01, 1'b0, 4'b0000}));
    @(negedge Hclk);
    chk("miss_t2", 64'({Hresp, Hreadyout, Pselx}), 64'({2'b01, 1'b1, 4'b0000}));
    @(negedge Hclk);
    chk("miss_t3", 64'({Hresp, Hreadyout}), 64'({2'b00, 1'b1}));
    idle_cycles(1);

    // Decode miss just below BASE, then hit at the last word of the map
    issue(32'h7FFF_FFFC, 1, 32'h1111_1111, 1, mk(1, 0, 0, 0, 0, 0));
    idle_cycles(3);
    cfg_rdata = 32'h0000_00FF;
    issue(32'h8FFF_FFFC, 0, 32'h0, 1, mk(0, 32'h8FFF_FFFC, 4'b1000, 0, 0, 32'h0000_00FF));
    idle_cycles(3);

    // Slave error
    cfg_err = 1;
    issue(32'h8000_0008, 1, 32'h0000_0001, 1, mk(1, 0, 0, 0, 0, 0));
    @(negedge Hclk);
    @(negedge Hclk);
    @(negedge Hclk);
    chk("slverr_acc", 64'({Penable, Pselx, Hreadyout}), 64'({1'b1, 4'b0001, 1'b0}));
    @(negedge Hclk);
    chk("slverr_err1", 64'({Hresp, Hreadyout, Pselx, Penable}), 64'({2'b01, 1'b0, 4'b0000, 1'b0}));
    @(negedge Hclk);
    chk("slverr_err2", 64'({Hresp, Hreadyout}), 64'({2'b01, 1'b1}));
    cfg_err = 0;
    idle_cycles(2);

    // Timeout: four ACCESS cycles with Pready low, then ERR1
    cfg_hang = 1;
    issue(32'h8000_0000, 0, 32'h0, 1, mk(1, 0, 0, 0, 0, 0));
    @(negedge Hclk);
    for (int k = 0; k < 4; k++) begin
      @(negedge Hclk);
      chk("to_access", 64'({Penable, Hreadyout}), 64'b10);
    end
    @(negedge Hclk);
    chk("to_err1", 64'({Hresp, Hreadyout, Penable}), 64'({2'b01, 1'b0, 1'b0}));
    cfg_hang = 0;
    idle_cycles(3);

    // Pready arrives as the counter reaches TIMEOUT-1: completion wins
    cfg_wait = 3; cfg_rdata = 32'h0BAD_F00D;
    issue(32'h8400_0020, 0, 32'h0, 1, mk(0, 32'h8400_0020, 4'b0010, 0, 0, 32'h0BAD_F00D));
    repeat (6) @(negedge Hclk);
    chk("to_edge_idle", 64'({Hresp, Hreadyout, Penable}), 64'({2'b00, 1'b1, 1'b0}));
    cfg_wait = 0;
    idle_cycles(1);

    // BUSY and Hreadyin=0 transfers are ignored
    Haddr = 32'h8000_0000; Hwrite = 1'b0; Htrans = 2'b01;
    repeat (2) begin
      @(negedge Hclk);
      chk("busy_ignored", 64'({Pselx, Hreadyout}), 64'({4'b0000, 1'b1}));
    end
    Htrans = 2'b10; Hreadyin = 1'b0;
    repeat (2) begin
      @(negedge Hclk);
      chk("nordy_ignored", 64'({Pselx, Hreadyout}), 64'({4'b0000, 1'b1}));
    end
    Htrans = 2'b00; Hreadyin = 1'b1;
    idle_cycles(1);

    // Reset asserted during ACCESS aborts the transfer
    cfg_hang = 1;
    issue(32'h8400_0000, 0, 32'h0, 0, mk(0, 0, 0, 0, 0, 0));
    @(negedge Hclk);
    @(negedge Hclk);
    chk("abort_in_access", 64'({Penable, Pselx}), 64'({1'b1, 4'b0010}));
    @(posedge Hclk);
    #1 Hresetn = 1'b0;
    @(negedge Hclk);
    @(negedge Hclk);
    chk("abort_rst", 64'({Penable, Pselx, Hreadyout, Hresp}), 64'({1'b0, 4'b0000, 1'b1, 2'b00}));
    cfg_hang = 0;
    @(posedge Hclk);
    #1 Hresetn = 1'b1;
    idle_cycles(1);

    // Recovery after reset
    issue(32'h8C00_00FC, 1, 32'h5A5A_5A5A, 1, mk(0, 32'h8C00_00FC, 4'b1000, 1, 32'h5A5A_5A5A, 0));
    idle_cycles(5);

    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
